// File: rtl/cmd_arbiter.sv
// rtl/cmd_arbiter.sv - two-requester command arbiter feeding a run-control FSM
module cmd_arbiter #(
    parameter int unsigned WAIT_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_cmd0,
    input  logic [1:0] req_cmd1,
    output logic [1:0] req_ready,
    input  logic [1:0] fsm_status,
    output logic       start_o,
    output logic       stop_o,
    output logic       reset_o,
    output logic       busy,
    output logic       err,
    output logic [1:0] err_code,
    output logic       last_grant
);

    typedef enum logic [1:0] {
        ST_ARB   = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_RESET = 2'b10;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUNNING = 2'b01;
    localparam logic [1:0] ST_PAUSED  = 2'b10;

    localparam logic [7:0] LP_WAIT_MAX = 8'(WAIT_MAX);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_cmd;
    logic [7:0] r_cnt;
    logic [1:0] r_err_code;
    logic       r_last_grant;

    logic       w_winner;
    logic       w_xfer;
    logic [1:0] w_sel_cmd;
    logic       w_legal;
    logic [1:0] w_exp;
    logic       w_done;
    logic [7:0] w_cnt_next;
    logic       w_timeout;

    // A lone reset command beats the round-robin pointer when both requesters are valid.
    always_comb begin
        w_winner = 1'b0;
        case (req_valid)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            2'b11: begin
                if ((req_cmd0 == CMD_RESET) != (req_cmd1 == CMD_RESET))
                    w_winner = (req_cmd1 == CMD_RESET);
                else
                    w_winner = ~r_last_grant;
            end
            default: w_winner = 1'b0;
        endcase
    end

    assign w_xfer    = (r_state == ST_ARB) && (req_valid != 2'b00);
    assign req_ready = w_xfer ? (w_winner ? 2'b10 : 2'b01) : 2'b00;
    assign w_sel_cmd = w_winner ? req_cmd1 : req_cmd0;

    always_comb begin
        w_legal = 1'b0;
        w_exp   = ST_IDLE;
        case (r_cmd)
            CMD_START: begin
                w_legal = (fsm_status == ST_IDLE) || (fsm_status == ST_PAUSED);
                w_exp   = ST_RUNNING;
            end
            CMD_STOP: begin
                w_legal = (fsm_status == ST_RUNNING);
                w_exp   = ST_PAUSED;
            end
            CMD_RESET: begin
                w_legal = (fsm_status == ST_RUNNING) || (fsm_status == ST_PAUSED);
                w_exp   = ST_IDLE;
            end
            default: begin
                w_legal = 1'b0;
                w_exp   = ST_IDLE;
            end
        endcase
    end

    assign w_done     = (fsm_status == w_exp);
    assign w_cnt_next = r_cnt + 8'd1;
    assign w_timeout  = (w_cnt_next == LP_WAIT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_ARB;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        start_o = 1'b0;
        stop_o  = 1'b0;
        reset_o = 1'b0;
        err     = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (w_xfer)
                    w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (w_legal) begin
                    start_o = (r_cmd == CMD_START);
                    stop_o  = (r_cmd == CMD_STOP);
                    reset_o = (r_cmd == CMD_RESET);
                    w_next  = ST_WAIT;
                end else begin
                    err    = 1'b1;
                    w_next = ST_ARB;
                end
            end
            ST_WAIT: begin
                if (w_done) begin
                    w_next = ST_ARB;
                end else if (w_timeout) begin
                    err    = 1'b1;
                    w_next = ST_ARB;
                end
            end
            default: w_next = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd        <= CMD_START;
            r_cnt        <= 8'd0;
            r_err_code   <= 2'b00;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_xfer) begin
                        r_cmd        <= w_sel_cmd;
                        r_last_grant <= w_winner;
                    end
                end
                ST_ISSUE: begin
                    r_cnt      <= 8'd0;
                    r_err_code <= w_legal ? 2'b00 : 2'b01;
                end
                ST_WAIT: begin
                    if (!w_done) begin
                        r_cnt <= w_cnt_next;
                        if (w_timeout)
                            r_err_code <= 2'b10;
                    end
                end
                default: r_cnt <= 8'd0;
            endcase
        end
    end

    assign busy       = (r_state != ST_ARB);
    assign err_code   = r_err_code;
    assign last_grant = r_last_grant;

endmodule

// File: tb/tb_cmd_arbiter.sv
// tb/tb_cmd_arbiter.sv - directed self-checking bench for cmd_arbiter
module tb_cmd_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_cmd0;
    logic [1:0] req_cmd1;
    logic [1:0] req_ready;
    logic [1:0] fsm_status;
    logic       start_o;
    logic       stop_o;
    logic       reset_o;
    logic       busy;
    logic       err;
    logic [1:0] err_code;
    logic       last_grant;

    int total;
    int bad;

    cmd_arbiter #(.WAIT_MAX(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_cmd0   (req_cmd0),
        .req_cmd1   (req_cmd1),
        .req_ready  (req_ready),
        .fsm_status (fsm_status),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .reset_o    (reset_o),
        .busy       (busy),
        .err        (err),
        .err_code   (err_code),
        .last_grant (last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_cmd0   = 2'b00;
        req_cmd1   = 2'b00;
        fsm_status = 2'b00;

        // reset state
        nxt();
        nxt();
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_start", start_o, 1'b0);
        chk1("rst_stop", stop_o, 1'b0);
        chk1("rst_reset", reset_o, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk2("rst_err_code", err_code, 2'b00);
        chk1("rst_last_grant", last_grant, 1'b1);
        chk2("rst_ready", req_ready, 2'b00);
        rst = 1'b0;

        // single start from req0 with a responsive FSM
        nxt();
        req_valid = 2'b01; req_cmd0 = 2'b00;
        #1;
        chk2("s1_ready_T", req_ready, 2'b01);
        chk1("s1_busy_T", busy, 1'b0);
        nxt();
        req_valid = 2'b00;
        #1;
        chk1("s1_start_T1", start_o, 1'b1);
        chk1("s1_stop_T1", stop_o, 1'b0);
        chk1("s1_reset_T1", reset_o, 1'b0);
        chk1("s1_busy_T1", busy, 1'b1);
        chk1("s1_err_T1", err, 1'b0);
        chk1("s1_last_grant", last_grant, 1'b0);
        chk2("s1_ready_T1", req_ready, 2'b00);
        nxt();
        fsm_status = 2'b01;
        #1;
        chk1("s1_start_T2", start_o, 1'b0);
        chk1("s1_busy_T2", busy, 1'b1);
        chk1("s1_err_T2", err, 1'b0);
        nxt();
        #1;
        chk1("s1_busy_T3", busy, 1'b0);
        chk1("s1_err_T3", err, 1'b0);
        chk2("s1_err_code_T3", err_code, 2'b00);

        // both valid with start, tie broken by pointer, second start illegal
        fsm_status = 2'b00;
        do_reset();
        nxt();
        req_valid = 2'b11; req_cmd0 = 2'b00; req_cmd1 = 2'b00;
        #1;
        chk2("s2_ready_T", req_ready, 2'b01);
        nxt();
        req_valid = 2'b10;
        #1;
        chk1("s2_start_T1", start_o, 1'b1);
        chk2("s2_ready_T1", req_ready, 2'b00);
        nxt();
        fsm_status = 2'b01;
        #1;
        chk2("s2_ready_T2", req_ready, 2'b00);
        chk1("s2_busy_T2", busy, 1'b1);
        nxt();
        #1;
        chk2("s2_ready_T3", req_ready, 2'b10);
        chk1("s2_last_grant_T3", last_grant, 1'b0);
        nxt();
        req_valid = 2'b00;
        #1;
        chk1("s2_err_T4", err, 1'b1);
        chk1("s2_start_T4", start_o, 1'b0);
        chk1("s2_last_grant_T4", last_grant, 1'b1);
        nxt();
        #1;
        chk1("s2_err_T5", err, 1'b0);
        chk2("s2_err_code_T5", err_code, 2'b01);
        chk1("s2_busy_T5", busy, 1'b0);

        // stop vs reset while RUNNING: reset wins against the pointer
        req_valid = 2'b11; req_cmd0 = 2'b01; req_cmd1 = 2'b10;
        #1;
        chk2("s3_ready_T", req_ready, 2'b10);
        nxt();
        req_valid = 2'b00;
        #1;
        chk1("s3_reset_T1", reset_o, 1'b1);
        chk1("s3_stop_T1", stop_o, 1'b0);
        chk1("s3_last_grant", last_grant, 1'b1);
        chk2("s3_err_code_T1", err_code, 2'b01);
        nxt();
        fsm_status = 2'b00;
        #1;
        chk1("s3_reset_T2", reset_o, 1'b0);
        chk2("s3_err_code_T2", err_code, 2'b00);
        nxt();
        #1;
        chk1("s3_busy_T3", busy, 1'b0);

        // start with FSM stuck in IDLE: timeout on WAIT cycle 8
        req_valid = 2'b01; req_cmd0 = 2'b00;
        #1;
        chk2("s4_ready_T", req_ready, 2'b01);
        nxt();
        req_valid = 2'b00;
        #1;
        chk1("s4_start_T1", start_o, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            nxt();
            #1;
            chk1("s4_err_wait", err, 1'b0);
            chk1("s4_busy_wait", busy, 1'b1);
        end
        nxt();
        #1;
        chk1("s4_err_T9", err, 1'b1);
        chk1("s4_busy_T9", busy, 1'b1);
        nxt();
        #1;
        chk1("s4_err_T10", err, 1'b0);
        chk2("s4_err_code_T10", err_code, 2'b10);
        chk1("s4_busy_T10", busy, 1'b0);

        // reserved command from req1
        req_valid = 2'b10; req_cmd1 = 2'b11;
        #1;
        chk2("s5_ready_T", req_ready, 2'b10);
        chk2("s5_err_code_held_T", err_code, 2'b10);
        nxt();
        req_valid = 2'b00;
        #1;
        chk1("s5_start_T1", start_o, 1'b0);
        chk1("s5_stop_T1", stop_o, 1'b0);
        chk1("s5_reset_T1", reset_o, 1'b0);
        chk1("s5_err_T1", err, 1'b1);
        chk2("s5_err_code_held_T1", err_code, 2'b10);
        nxt();
        #1;
        chk2("s5_err_code_T2", err_code, 2'b01);
        chk1("s5_busy_T2", busy, 1'b0);
        chk1("s5_last_grant", last_grant, 1'b1);

        // rst raised right after the transfer edge aborts the start
        nxt();
        req_valid = 2'b01; req_cmd0 = 2'b00;
        #1;
        chk2("s6_ready_T", req_ready, 2'b01);
        chk1("s6_last_grant_T", last_grant, 1'b1);
        @(posedge clk);
        rst = 1'b1;
        req_valid = 2'b00;
        #1;
        chk1("s6_start_rst", start_o, 1'b0);
        nxt();
        #1;
        chk1("s6_start_T1", start_o, 1'b0);
        chk1("s6_busy_T1", busy, 1'b0);
        chk1("s6_last_grant_T1", last_grant, 1'b1);
        chk2("s6_err_code_T1", err_code, 2'b00);
        nxt();
        rst = 1'b0;
        #1;
        chk1("s6_busy_T2", busy, 1'b0);
        chk1("s6_start_T2", start_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
